// File: rtl/ram_core.sv
// Single-port synchronous RAM with a registered read port; one read or write per rising edge.
// Reset clears only the output register, so stored words survive a reset pulse.
module ram_core #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rw,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  wr_en;
    logic                  rd_en;

    assign wr_en = rst_n & ~rw;
    assign rd_en = rst_n & rw;

    // Array port carries no reset so it maps onto block RAM; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= din;
        end
    end

    // Output register: loads only on a read, holds through writes.
    always_comb begin
        dout_d = dout_q;
        if (rd_en) begin
            dout_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_ram_core.sv
// Randomised scoreboard bench for ram_core: stimulus pushes expected dout per edge,
// a monitor pops and compares one cycle later against an associative-array memory model.
module tb_ram_core;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          rw;
    logic [DW-1:0] dout;

    ram_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (addr),
        .din  (din),
        .rw   (rw),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] val;
        string         name;
    } exp_t;

    exp_t                  sb[$];
    logic [DW-1:0]         model[int unsigned];
    int unsigned           wr_addrs[$];
    logic [DW-1:0]         last_dout;
    int                    checks;
    int                    errors;
    bit                    stim_done;

    // Apply one operation on the falling edge and record what dout must be after the next rising edge.
    task automatic do_op(input bit rst_v, input bit rw_v, input logic [31:0] wide_addr,
                         input logic [DW-1:0] din_v, input string name);
        int unsigned a;
        exp_t        e;
        @(negedge clk);
        rst_n = rst_v;
        rw    = rw_v;
        addr  = AW'(wide_addr);
        din   = din_v;
        a     = wide_addr % (1 << AW);
        if (!rst_v) begin
            last_dout = '0;
        end else if (!rw_v) begin
            if (!model.exists(a)) wr_addrs.push_back(a);
            model[a] = din_v;
        end else begin
            last_dout = model.exists(a) ? model[a] : 'x;
        end
        e.val  = last_dout;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: one expected value per edge after stimulus starts.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (dout !== e.val) begin
                    errors++;
                    $display("FAIL %s: dout=%h expected=%h", e.name, dout, e.val);
                end else begin
                    $display("ok   %s: dout=%h", e.name, dout);
                end
            end
        end
    end

    initial begin
        logic [31:0] wide;
        int          n;
        checks    = 0;
        errors    = 0;
        stim_done = 0;
        last_dout = '0;
        rst_n     = 1'b0;
        rw        = 1'b1;
        addr      = 16'hABCD;
        din       = '0;

        do_op(0, 1, 32'h0000ABCD, 32'h0,        "reset_edge1");
        do_op(0, 1, 32'h0000ABCD, 32'h0,        "reset_edge2");
        do_op(1, 0, 32'h0000ABCD, 32'h0000FCAB, "write_no_thru");
        do_op(1, 1, 32'h0000ABCD, 32'h11001100, "read_abcd");
        do_op(1, 0, 32'h00000011, 32'h00110011, "write_0011");
        do_op(1, 1, 32'h00000011, 32'h01011010, "read_0011");
        do_op(1, 1, 32'h0000ABCD, 32'h0,        "read_abcd_indep");
        wide = 32'h11110011;
        do_op(1, 1, wide,         32'h0,        "read_trunc");
        do_op(0, 1, 32'h0000ABCD, 32'h0,        "reset_pulse");
        do_op(1, 1, 32'h0000ABCD, 32'h0,        "read_after_rst");
        do_op(1, 0, 32'h00000000, 32'hDEADBEEF, "write_min");
        do_op(1, 0, 32'h0000FFFF, 32'hCAFEF00D, "write_max");
        do_op(1, 1, 32'h00000000, 32'h0,        "read_min");
        do_op(1, 1, 32'h0000FFFF, 32'h0,        "read_max");
        do_op(1, 0, 32'h00001234, 32'h55AA55AA, "write_hold");
        do_op(0, 0, 32'h00000000, 32'h12345678, "reset_no_write");
        do_op(1, 1, 32'h00000000, 32'h0,        "read_min_kept");
        do_op(1, 1, 32'h00001234, 32'h0,        "read_hold_addr");

        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(0, 19);
            if (n == 0) begin
                do_op(0, $urandom_range(0, 1), $urandom, $urandom, "rand_reset");
            end else if (n < 9 || wr_addrs.size() == 0) begin
                do_op(1, 0, $urandom, $urandom, "rand_write");
            end else begin
                wide = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                wide = wide | ($urandom & 32'hFFFF0000);
                do_op(1, 1, wide, $urandom, "rand_read");
            end
        end
        stim_done = 1;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_core.md
Name: ram_core

Overview:
- Single-port synchronous random-access memory: 2^ADDR_WIDTH words of DATA_WIDTH bits.
- One shared address bus, one read/write select, a registered read-data output.
- Used as the general-purpose data store in the processor datapath.
- Reads and writes happen on the rising clock edge.

Parameters:
- ADDR_WIDTH, 16, address bus width; depth = 2^ADDR_WIDTH words (65536 at default).
- DATA_WIDTH, 32, width of each word and of din/dout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- addr  input  ADDR_WIDTH  word address; no byte addressing.
- din  input  DATA_WIDTH  write data.
- rw  input  1  operation select: 0 = write, 1 = read.
- dout  output  DATA_WIDTH  registered read data.

Behaviour:
- Storage: array mem[0 .. 2^ADDR_WIDTH-1] of DATA_WIDTH bits.
- All actions occur on the rising edge of clk; inputs are sampled there only.
- Reset (rst_n = 0 at a rising edge):
  - dout <= 0.
  - No write occurs, whatever the value of rw.
  - Memory contents are not cleared; they are retained across reset.
  - Reset has priority over rw.
- Write (rst_n = 1, rw = 0):
  - mem[addr] <= din.
  - dout holds its previous value; no write-through.
- Read (rst_n = 1, rw = 1):
  - dout <= mem[addr]; one-cycle latency, valid after the edge.
  - dout then holds until the next read or reset.
- Read of a never-written location returns undefined data (X in simulation). The design does not initialise the array.
- Write followed by read of the same address on the next edge returns the new data; there is no hazard, since each edge is a single operation.
- Address range:
  - Every ADDR_WIDTH-bit value is legal, with no wrap logic.
  - Wider values driven by the integrator are truncated to the low ADDR_WIDTH bits by port width. Example: 0x1111ABCD -> 0xABCD.
- No handshake, no busy or error signal. One operation per cycle; the block is always ready.
- Reset asserted mid-sequence: only dout is affected. Previously written data is readable after reset is released.
- X or Z on rw is not defined; the integrator must drive rw valid at every edge while rst_n = 1.
- The memory array is implemented as inferable synchronous RAM (block RAM on FPGA). No asynchronous read path.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with rw = 1 and addr = 0xABCD -> dout = 0x00000000. Then release and write 0x0000FCAB to 0xABCD -> dout still 0x00000000 after the write edge.
- Write/read same address:
  - Edge 1: rw = 0, addr = 0xABCD, din = 0x0000FCAB.
  - Edge 2: rw = 1, addr = 0xABCD, din = 0x11001100.
  - Expect dout = 0x0000FCAB after edge 2, and mem[0xABCD] unchanged (din ignored on read).
- Second location: write 0x00110011 to 0x0011, then read 0x0011 with din = 0x01011010 -> dout = 0x00110011. A following read of 0xABCD -> dout = 0x0000FCAB (locations independent).
- Truncation: drive a 32-bit value 0x11110011 onto addr -> access hits 0x0011; read returns 0x00110011.
- Reset retention: after writes above, pulse rst_n low for one edge -> dout = 0. Then read 0xABCD -> 0x0000FCAB.
- Boundaries and hold:
  - Write 0xDEADBEEF to 0x0000 and 0xCAFEF00D to 0xFFFF; read both back -> exact values.
  - Perform a write with rw = 0 and confirm dout holds the last read value (0xCAFEF00D).
- Drive all inputs away from rising edges (e.g. on falling edges) to avoid sampling races.
